// File: rtl/irq_arbiter_pkg.sv
// Shared types for the interrupt arbiter: FSM state encoding and default source count.
package irq_arbiter_pkg;

  localparam int N_SRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: valid when any request is set, idx of the lowest set bit.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Walk from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter sitting behind the per-source irq gates: picks one pending, enabled source,
// hands it to the core via irq_req/claim/complete, and acks the gate (ack[i] -> gate i) on claim.
//
// Handshake: irq_req stays high with irq_id stable until the core asserts claim (sampled only in
// REQ); claim yields a one-cycle ack pulse the next cycle and the arbiter holds busy until complete
// (sampled only in SERVICE). A request whose source loses its enable before claim is withdrawn.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] ack,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  output logic [N_SRC-1:0] en_mask,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             claim,
  input  logic             complete,
  output logic             busy,
  output arb_state_e       dbg_state
);

  arb_state_e       state_d, state_q;
  logic [N_SRC-1:0] en_mask_d, en_mask_q;
  logic [N_SRC-1:0] ack_d, ack_q;
  logic [ID_W-1:0]  id_d, id_q;

  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] id_onehot;
  logic             win_valid;
  logic [ID_W-1:0]  win_idx;

  assign cand      = pending & en_mask_q;
  assign id_onehot = N_SRC'(1) << id_q;

  prio_enc #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    en_mask_d = en_mask_q;
    if (en_we) en_mask_d = en_wdata;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          id_d    = win_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Claim takes precedence over withdrawal when both happen together.
        if (claim) begin
          ack_d   = id_onehot;
          state_d = ST_SERVICE;
        end else if ((cand & id_onehot) == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      en_mask_q <= '0;
      ack_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      en_mask_q <= en_mask_d;
      ack_q     <= ack_d;
      id_q      <= id_d;
    end
  end

  assign ack       = ack_q;
  assign en_mask   = en_mask_q;
  assign irq_req   = (state_q == ST_REQ);
  assign busy      = (state_q == ST_SERVICE);
  assign irq_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: a cycle table of inputs/expected outputs plus a
// hand-written back-to-back service sequence, all checked through an expected-value queue.
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int EW = 1 + IW + N + 1 + N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pending;
  logic [N-1:0]  ack;
  logic          en_we;
  logic [N-1:0]  en_wdata;
  logic [N-1:0]  en_mask;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic          claim;
  logic          complete;
  logic          busy;
  arb_state_e    dbg_state;

  irq_arbiter #(.N_SRC(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pending   (pending),
    .ack       (ack),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .en_mask   (en_mask),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .claim     (claim),
    .complete  (complete),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          rst_n;
    logic [N-1:0]  pending;
    logic          en_we;
    logic [N-1:0]  en_wdata;
    logic          claim;
    logic          complete;
    logic          e_req;
    logic [IW-1:0] e_id;
    logic [N-1:0]  e_ack;
    logic          e_busy;
    logic [N-1:0]  e_mask;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic logic [EW-1:0] pack_exp(logic r, logic [IW-1:0] id, logic [N-1:0] a,
                                             logic b, logic [N-1:0] m);
    return {r, id, a, b, m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [N-1:0] p, input logic we,
                       input logic [N-1:0] wd, input logic c, input logic cp);
    rst_n    = r;
    pending  = p;
    en_we    = we;
    en_wdata = wd;
    claim    = c;
    complete = cp;
  endtask

  // One clock: outputs after the edge are popped from the queue and compared.
  task automatic step_check(input int tag);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL step%0d: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      a = pack_exp(irq_req, irq_id, ack, busy, en_mask);
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got req=%b id=%0d ack=%02h busy=%b mask=%02h, want req=%b id=%0d ack=%02h busy=%b mask=%02h",
                 tag, a[EW-1], a[EW-2 -: IW], a[N+N -: N], a[N], a[N-1:0],
                 e[EW-1], e[EW-2 -: IW], e[N+N -: N], e[N], e[N-1:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    //            rst pend  we wdata cl cp | req id ack   busy mask
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h04};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 8'h04};
    vecs[4]  = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 8'h04};
    vecs[5]  = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 8'h04};
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 8'h04};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 8'h04};
    vecs[8]  = '{1'b1, 8'h30, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 8'hFF};
    vecs[9]  = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'hFF};
    vecs[10] = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h10, 1'b1, 8'hFF};
    vecs[11] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 8'hFF};
    vecs[12] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'hFF};
    vecs[13] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 8'hFF};
    vecs[14] = '{1'b1, 8'h21, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'hFF};
    vecs[15] = '{1'b1, 8'h21, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h20, 1'b1, 8'hFF};
    vecs[16] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1, 8'hFF};
    vecs[17] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 8'hFF};
    vecs[18] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'hFF};
    vecs[19] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 8'hFF};
    vecs[20] = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF};
    vecs[21] = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'hFF};
    vecs[22] = '{1'b1, 8'h08, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'h00};
    vecs[23] = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 8'h00};
    vecs[24] = '{1'b1, 8'h08, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 8'h40};
    vecs[25] = '{1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'h40};
    vecs[26] = '{1'b1, 8'h48, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'h00};
    vecs[27] = '{1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 8'h40, 1'b1, 8'h00};
    vecs[28] = '{1'b1, 8'h09, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd6, 8'h00, 1'b1, 8'hFF};
    vecs[29] = '{1'b1, 8'h09, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b1, 8'hFF};
    vecs[30] = '{1'b0, 8'h09, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[31] = '{1'b1, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};

    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].pending, vecs[i].en_we, vecs[i].en_wdata,
            vecs[i].claim, vecs[i].complete);
      exp_q.push_back(pack_exp(vecs[i].e_req, vecs[i].e_id, vecs[i].e_ack,
                               vecs[i].e_busy, vecs[i].e_mask));
      step_check(i);
      if (i == 0) check_val("reset_state", int'(dbg_state), int'(ST_IDLE));
    end

    // Back-to-back service: id 2 then id 3, with exactly one IDLE cycle between.
    drive(1'b1, 8'h0C, 1'b1, 8'h0C, 1'b0, 1'b0);
    exp_q.push_back(pack_exp(1'b0, 3'd0, 8'h00, 1'b0, 8'h0C));
    step_check(100);
    drive(1'b1, 8'h0C, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_q.push_back(pack_exp(1'b1, 3'd2, 8'h00, 1'b0, 8'h0C));
    step_check(101);
    drive(1'b1, 8'h0C, 1'b0, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(pack_exp(1'b0, 3'd2, 8'h04, 1'b1, 8'h0C));
    step_check(102);
    drive(1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_q.push_back(pack_exp(1'b0, 3'd2, 8'h00, 1'b0, 8'h0C));
    step_check(103);

    drive(1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!irq_req && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("b2b_idle_gap", n, 1);
    check_val("b2b_second_id", int'(irq_id), 3);
    check_val("b2b_no_ack", int'(ack), 0);
    check_val("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (2..32).
REQ-002 SHALL have parameter ID_W, default 3, width of the source ID; ID_W = clog2(N_SRC).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pending  input  N_SRC  per-source level from the per-source irq gates; held until acked.
REQ-006 SHALL have port ack  output  N_SRC  one-hot, one-cycle pulse that clears the matching gate's pending.
REQ-007 SHALL have port en_we  input  1  enable-mask write strobe.
REQ-008 SHALL have port en_wdata  input  N_SRC  new enable mask.
REQ-009 SHALL have port en_mask  output  N_SRC  current enable mask.
REQ-010 SHALL have port irq_req  output  1  interrupt request to the core.
REQ-011 SHALL have port irq_id  output  ID_W  ID of the requested or in-service source.
REQ-012 SHALL have port claim  input  1  core takes the interrupt, sampled only in REQ.
REQ-013 SHALL have port complete  input  1  core finished the handler, sampled only in SERVICE.
REQ-014 SHALL have port busy  output  1  high in SERVICE.

Function
REQ-015 SHALL keep a registered enable mask; en_we loads en_wdata, and the new mask SHALL take effect in arbitration the next cycle.
REQ-016 SHALL form candidates = pending & en_mask, with the lowest index as highest priority.
REQ-017 SHALL implement FSM states IDLE, REQ and SERVICE.
REQ-018 In IDLE with candidates != 0, SHALL latch the winner into irq_id and move to REQ; irq_req SHALL rise the next cycle (1-cycle latency).
REQ-019 In REQ, irq_req SHALL be 1 and irq_id SHALL be held stable; the winner SHALL NOT be re-arbitrated even if a higher-priority source arrives.
REQ-020 In REQ with claim=1, SHALL pulse ack[irq_id] for exactly one cycle (the cycle after claim), drop irq_req, and move to SERVICE.
REQ-021 In REQ with claim=0 and the latched source no longer a candidate (enable cleared), SHALL withdraw irq_req and return to IDLE without ack.
REQ-022 When claim=1 and withdrawal coincide in the same cycle, claim SHALL win.
REQ-023 In SERVICE, irq_req SHALL be 0, busy SHALL be 1, irq_id SHALL be held, and new pending SHALL wait (no nesting).
REQ-024 In SERVICE with complete=1, SHALL return to IDLE; arbitration SHALL resume the following cycle, so back-to-back service has a minimum 1 IDLE cycle.
REQ-025 SHALL ignore claim outside REQ and complete outside SERVICE.
REQ-026 ack SHALL be all-zero except during the single pulse cycle of REQ-020.
REQ-027 An en_we during REQ or SERVICE SHALL update the mask but SHALL NOT alter irq_id.

Reset
REQ-028 On rst_n=0 at a clock edge, SHALL enter IDLE with en_mask=0, irq_req=0, irq_id=0, ack=0 and busy=0, from any state including mid-service.
REQ-029 SHALL NOT generate any ack during or on exit from reset.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/REQ/SERVICE) and the default N_SRC in the shared cpu package.
REQ-031 SHALL use one sub-module, prio_enc (parameterised lowest-index-first priority encoder giving valid and index).
REQ-032 SHALL instantiate irq_arbiter downstream of N_SRC irq_gate instances, with ack[i] wired to gate i's ack.

Verification
REQ-033 Single source: en_mask=0x04, pending[2] rises -> irq_req=1 and irq_id=2 one cycle later; claim -> ack=0x04 one cycle, busy=1.
REQ-034 Priority: pending=0x30 with mask 0xFF -> irq_id=4; after complete, irq_id=5 after one IDLE cycle.
REQ-035 Masking and withdrawal: in REQ id=3, write mask 0x00 -> irq_req falls next cycle, no ack, FSM returns to IDLE.
REQ-036 Collision: claim and mask clear in the same cycle -> ack[id] pulses and the FSM enters SERVICE.
REQ-037 No nesting and spurious handshakes: pending[0] arrives during SERVICE id=6 -> no irq_req until complete; claim in IDLE and complete in REQ are ignored.
REQ-038 Reset mid-service: rst_n=0 in SERVICE -> all outputs 0 and en_mask=0 the next cycle, with no ack pulse.
